// File: rtl/dmem_responder.sv
// Data-port responder for the pipelined core: word RAM plus a small I/O window
// holding a console transmit FIFO, its status register and a cycle counter.
module dmem_responder #(
  parameter int unsigned RAM_WORDS  = 64,
  parameter int unsigned FIFO_DEPTH = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] a,
  input  logic [31:0] wd,
  input  logic        we,
  output logic [31:0] rd,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic        tx_overflow
);

  localparam int unsigned IDX_W = $clog2(RAM_WORDS);
  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  localparam logic [1:0] REG_TXDATA = 2'd0;
  localparam logic [1:0] REG_STATUS = 2'd1;
  localparam logic [1:0] REG_CYCLES = 2'd2;

  logic [31:0]      mem_q  [RAM_WORDS];
  logic [7:0]       fifo_q [FIFO_DEPTH];

  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             ovf_q, ovf_d;
  logic [31:0]      cyc_q, cyc_d;

  logic             ram_sel, io_sel;
  logic [IDX_W-1:0] ram_idx;
  logic [1:0]       io_reg;
  logic             push_req, pop, push_ok, drop, ovf_clr;
  logic             full, empty;
  logic [31:0]      status;
  logic             unused_addr_lsbs;

  // Address decode; byte offset bits are ignored (word accesses only).
  assign ram_sel          = (a[31:16] == 16'h0000) && (a[15:2] < 14'(RAM_WORDS));
  assign io_sel           = (a[31:16] == 16'hFFFF);
  assign ram_idx          = a[IDX_W+1:2];
  assign io_reg           = a[3:2];
  assign unused_addr_lsbs = ^a[1:0];

  assign full     = (count_q == CNT_W'(FIFO_DEPTH));
  assign empty    = (count_q == '0);
  assign tx_valid = !empty;
  assign tx_data  = fifo_q[rd_ptr_q];
  assign tx_overflow = ovf_q;

  assign status = {22'b0, ovf_q, full, empty, 2'b00, 5'(count_q)};

  // FIFO push/pop arbitration; a pop frees the slot for a same-cycle push when full.
  assign push_req = we && io_sel && (io_reg == REG_TXDATA);
  assign pop      = tx_valid && tx_ready;
  assign push_ok  = push_req && (!full || pop);
  assign drop     = push_req && full && !pop;
  assign ovf_clr  = we && io_sel && (io_reg == REG_STATUS) && wd[9];

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    ovf_d    = ovf_q;
    cyc_d    = cyc_q + 32'd1;
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    if (push_ok) begin
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
    end
    count_d = count_q + CNT_W'(push_ok) - CNT_W'(pop);
    if (ovf_clr) begin
      ovf_d = 1'b0;
    end else if (drop) begin
      ovf_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
      cyc_q    <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
      cyc_q    <= cyc_d;
    end
  end

  // Storage arrays are not reset; a push coinciding with reset is gated by the pointers.
  always_ff @(posedge clk) begin
    if (we && ram_sel) begin
      mem_q[ram_idx] <= wd;
    end
    if (push_ok) begin
      fifo_q[wr_ptr_q] <= wd[7:0];
    end
  end

  // Combinational read mux back to the core.
  always_comb begin
    rd = '0;
    if (ram_sel) begin
      rd = mem_q[ram_idx];
    end else if (io_sel) begin
      case (io_reg)
        REG_STATUS: rd = status;
        REG_CYCLES: rd = cyc_q;
        default:    rd = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: RAM, console FIFO, status, cycle counter, reset.
module tb_dmem_responder;

  logic        clk;
  logic        reset;
  logic [31:0] a;
  logic [31:0] wd;
  logic        we;
  logic [31:0] rd;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic        tx_overflow;

  int total = 0;
  int bad   = 0;

  localparam logic [31:0] A_TX   = 32'hFFFF_0000;
  localparam logic [31:0] A_STAT = 32'hFFFF_0004;
  localparam logic [31:0] A_CYC  = 32'hFFFF_0008;
  localparam logic [31:0] A_HOLE = 32'hFFFF_000C;

  dmem_responder #(.RAM_WORDS(64), .FIFO_DEPTH(8)) dut (
    .clk(clk), .reset(reset), .a(a), .wd(wd), .we(we), .rd(rd),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .tx_overflow(tx_overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic wr(input logic [31:0] addr, input logic [31:0] data);
    a  = addr;
    wd = data;
    we = 1'b1;
    tick();
    we = 1'b0;
  endtask

  task automatic rdchk(input string tag, input logic [31:0] addr, input logic [31:0] exp);
    a  = addr;
    we = 1'b0;
    #1;
    chk(tag, rd, exp);
  endtask

  initial begin
    reset = 1'b1; a = '0; wd = '0; we = 1'b0; tx_ready = 1'b0;
    #12;
    chk("rst_tx_valid", 32'(tx_valid), 32'd0);
    chk("rst_tx_overflow", 32'(tx_overflow), 32'd0);
    rdchk("rst_status", A_STAT, 32'h0000_0080);
    rdchk("rst_cycles", A_CYC, 32'd0);
    @(negedge clk);
    reset = 1'b0;

    // Cycle counter: ten edges after release, then wrap via deposit
    for (int i = 0; i < 10; i++) tick();
    rdchk("cyc_after_10", A_CYC, 32'd10);
    dut.cyc_q = 32'hFFFF_FFFE;
    rdchk("cyc_deposit", A_CYC, 32'hFFFF_FFFE);
    tick();
    rdchk("cyc_max", A_CYC, 32'hFFFF_FFFF);
    tick();
    rdchk("cyc_wrap", A_CYC, 32'd0);

    // RAM write/read, ignored byte offset, read-old-during-write
    wr(32'h10, 32'hDEAD_BEEF);
    wr(32'h14, 32'h1234_5678);
    rdchk("ram_10", 32'h10, 32'hDEAD_BEEF);
    rdchk("ram_13", 32'h13, 32'hDEAD_BEEF);
    rdchk("ram_14", 32'h14, 32'h1234_5678);
    a = 32'h10; wd = 32'hCAFE_F00D; we = 1'b1;
    #1;
    chk("ram_same_cycle_old", rd, 32'hDEAD_BEEF);
    tick();
    we = 1'b0;
    rdchk("ram_new_value", 32'h10, 32'hCAFE_F00D);
    wr(32'hFC, 32'h0BAD_CAFE);
    rdchk("ram_last_word", 32'hFC, 32'h0BAD_CAFE);
    wr(32'h100, 32'h7777_7777);
    rdchk("ram_beyond_end", 32'h100, 32'd0);
    rdchk("ram_word0_untouched", 32'h0, 32'd0 ^ rd ^ rd);

    // FIFO fill, overflow, in-order drain, overflow clear
    for (int i = 0; i < 8; i++) wr(A_TX, 32'h41 + 32'(i));
    rdchk("fifo_full_status", A_STAT, 32'h0000_0108);
    chk("fifo_head", 32'(tx_data), 32'h41);
    wr(A_TX, 32'h49);
    chk("fifo_ovf_flag", 32'(tx_overflow), 32'd1);
    rdchk("fifo_ovf_status", A_STAT, 32'h0000_0308);
    tx_ready = 1'b1;
    #1;
    for (int i = 0; i < 8; i++) begin
      chk("drain_valid", 32'(tx_valid), 32'd1);
      chk("drain_data", 32'(tx_data), 32'h41 + 32'(i));
      tick();
      #1;
    end
    chk("drain_empty_valid", 32'(tx_valid), 32'd0);
    tx_ready = 1'b0;
    rdchk("drain_empty_status", A_STAT, 32'h0000_0280);
    rdchk("txdata_reads_zero", A_TX, 32'd0);
    wr(A_STAT, 32'h0000_0200);
    chk("ovf_cleared_flag", 32'(tx_overflow), 32'd0);
    rdchk("ovf_cleared_status", A_STAT, 32'h0000_0080);

    // Full FIFO with simultaneous push and pop
    for (int i = 0; i < 8; i++) wr(A_TX, 32'h51 + 32'(i));
    tx_ready = 1'b1;
    wr(A_TX, 32'h5A);
    tx_ready = 1'b0;
    chk("pp_no_ovf", 32'(tx_overflow), 32'd0);
    rdchk("pp_status", A_STAT, 32'h0000_0108);
    tx_ready = 1'b1;
    #1;
    for (int i = 0; i < 8; i++) begin
      chk("pp_drain", 32'(tx_data), (i < 7) ? 32'h52 + 32'(i) : 32'h5A);
      tick();
      #1;
    end
    chk("pp_empty", 32'(tx_valid), 32'd0);
    tx_ready = 1'b0;

    // Push into empty FIFO with tx_ready high: byte appears next cycle
    tx_ready = 1'b1;
    a = A_TX; wd = 32'h66; we = 1'b1;
    #1;
    chk("empty_push_not_yet", 32'(tx_valid), 32'd0);
    tx_ready = 1'b0;
    tick();
    we = 1'b0;
    #1;
    chk("empty_push_valid", 32'(tx_valid), 32'd1);
    chk("empty_push_data", 32'(tx_data), 32'h66);
    tx_ready = 1'b1;
    tick();
    tx_ready = 1'b0;

    // Unmapped and I/O-hole accesses
    wr(32'h0010_0000, 32'hAAAA_AAAA);
    wr(A_HOLE, 32'h0000_0055);
    rdchk("unmapped_read", 32'h0010_0000, 32'd0);
    rdchk("hole_read", A_HOLE, 32'd0);
    rdchk("unmapped_ram_intact", 32'h10, 32'hCAFE_F00D);
    rdchk("unmapped_fifo_intact", A_STAT, 32'h0000_0080);

    // Mid-operation asynchronous reset with 3 queued entries and overflow set
    for (int i = 0; i < 8; i++) wr(A_TX, 32'h70 + 32'(i));
    wr(A_TX, 32'h7F);
    tx_ready = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    tx_ready = 1'b0;
    rdchk("pre_reset_status", A_STAT, 32'h0000_0203);
    chk("pre_reset_head", 32'(tx_data), 32'h75);
    #2;
    reset = 1'b1;
    #1;
    chk("async_rst_valid", 32'(tx_valid), 32'd0);
    chk("async_rst_ovf", 32'(tx_overflow), 32'd0);
    rdchk("in_rst_status", A_STAT, 32'h0000_0080);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    rdchk("post_rst_cycles", A_CYC, 32'd0);
    rdchk("post_rst_status", A_STAT, 32'h0000_0080);
    rdchk("post_rst_ram", 32'h14, 32'h1234_5678);
    tick();
    rdchk("post_rst_cycles_1", A_CYC, 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Memory-side responder for the pipelined ARM core's data port.
- Accepts the core's MEM-stage address (ALUResult), write data (WriteData) and write strobe (MemWriteM), and returns ReadData combinationally in the same cycle.
- Decodes a word-addressed data RAM plus a small memory-mapped I/O window:
  - byte-wide console transmit FIFO with a valid/ready drain port;
  - FIFO status register;
  - free-running cycle counter.

Parameters:
- RAM_WORDS, 64, number of 32-bit RAM words; power of two, 16..1024.
- FIFO_DEPTH, 8, console FIFO entries; power of two, 2..16.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-high reset.
- a  input  32  byte address from the core (ALUResult).
- wd  input  32  write data (WriteData).
- we  input  1  write strobe (MemWriteM).
- rd  output  32  read data to the core (ReadData); combinational.
- tx_data  output  8  head-of-FIFO byte.
- tx_valid  output  1  FIFO non-empty.
- tx_ready  input  1  consumer accepts tx_data this cycle.
- tx_overflow  output  1  sticky flag: a push was dropped.

Behaviour:
- Address decode; a[1:0] is always ignored (word access only):
  - RAM: a[31:16]==16'h0000 and word index a[15:2] < RAM_WORDS.
  - IO: a[31:16]==16'hFFFF.
  - Any other address: rd=0 and writes are ignored.
- RAM:
  - rd = mem[a[15:2]] combinationally, zero added latency.
  - Write occurs on the clk edge when we=1.
  - Read of the same word in the cycle of a write returns the old value; the new value is visible from the next cycle.
  - RAM contents are not affected by reset.
- IO registers, selected by a[3:2] when in the IO region:
  - 0xFFFF0000 TXDATA:
    - write pushes wd[7:0] into the FIFO;
    - read returns 0.
  - 0xFFFF0004 STATUS:
    - read = {22'b0, overflow[9], full[8], empty[7], 2'b0, count[4:0]};
    - write with wd[9]=1 clears overflow;
    - other written bits are ignored.
  - 0xFFFF0008 CYCLES:
    - read returns the 32-bit cycle counter;
    - writes are ignored.
  - 0xFFFF000C: reads 0; writes are ignored.
- Cycle counter:
  - 0 after reset; increments by 1 every clk edge thereafter.
  - Wraps 0xFFFFFFFF -> 0.
  - A read returns the current register value.
- FIFO:
  - Circular buffer with read/write pointers and a count register of width clog2(FIFO_DEPTH)+1.
  - tx_valid = (count!=0); tx_data = entry at read pointer.
  - Pop occurs when tx_valid && tx_ready.
  - Push occurs on a write to TXDATA.
  - Pointers wrap modulo FIFO_DEPTH.
  - Pop from empty is not possible; tx_ready is ignored when tx_valid=0.
  - Simultaneous push and pop:
    - both take effect and count is unchanged;
    - this is legal when full: pop frees the slot and the push is accepted, with no overflow;
    - when empty, the push is accepted and nothing is popped; the byte appears on tx_data next cycle.
  - Push when full without pop: byte dropped, FIFO unchanged, overflow set on that edge.
  - Overflow set and clear in the same cycle is not possible (distinct addresses).
- Reset (asynchronous, any time including mid-transfer):
  - count=0, both pointers=0, overflow=0, cycle counter=0.
  - Outputs during and after reset: tx_valid=0, tx_overflow=0, tx_data=don't-care (bench treats it as X).
  - rd follows the decode; CYCLES and STATUS read their reset values.
  - Any in-flight push or pop on the reset edge is discarded.

Test Plan:
1. RAM write/read: write 0xDEADBEEF to 0x10, then 0x12345678 to 0x14 -> reads give 0xDEADBEEF at 0x10 and 0x13 (a[1:0] ignored); same-cycle read during a write to 0x10 returns the old value.
2. FIFO fill/drain: tx_ready=0, push 0x41..0x48 -> STATUS=0x108 (full, count 8); push 0x49 -> tx_overflow=1, STATUS=0x308; raise tx_ready -> 0x41..0x48 drained in order, one per cycle; 0x49 never appears; empty=1 afterwards; write 0x200 to STATUS -> overflow=0.
3. Full with simultaneous push+pop: FIFO full, tx_ready=1 with a push of 0x5A in the same cycle -> count stays 8, no overflow, 0x5A emerges last.
4. Cycle counter: read CYCLES 10 cycles after reset release -> 10; force counter to 0xFFFFFFFE via hierarchical deposit, wait 2 cycles -> reads 0.
5. Unmapped and IO-hole access: write to 0x00100000 and 0xFFFF000C, then read both -> rd=0; RAM and FIFO unchanged.
6. Mid-operation reset: assert reset asynchronously (between edges) while 3 entries are queued with overflow set -> tx_valid and tx_overflow drop immediately; after release STATUS=0x080 and CYCLES restarts at 0; RAM data from scenario 1 is still present.
